// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM encodings,
// reset defaults and the PC alignment helper.
package if_fetch_unit_pkg;

  localparam int INSTR_W = 32;

  localparam logic [31:0]        RESET_PC_DEFAULT  = 32'h0000_3000;
  localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = '0;

  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: holds the PC and instruction handed to decode.
// Flush beats load, load beats bubble; with no control asserted it holds.
module if_id_reg
  import if_fetch_unit_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               load,
  input  logic               bubble,
  input  logic [31:0]        load_pc,
  input  logic [INSTR_W-1:0] load_instr,
  output logic [31:0]        id_pc,
  output logic [INSTR_W-1:0] id_instr,
  output logic               id_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_pc    <= '0;
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
    end else if (flush) begin
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
    end else if (load) begin
      id_pc    <= load_pc;
      id_instr <= load_instr;
      id_valid <= 1'b1;
    end else if (bubble) begin
      id_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC register, imem req/ack sequencing and
// redirect handling, feeding the IF/ID register.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0]        RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        npc,
  input  logic               stall,
  input  logic               flush,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ack,
  output logic [31:0]        IF_PC,
  output logic [31:0]        ID_PC,
  output logic [INSTR_W-1:0] ID_instr,
  output logic               ID_valid,
  output logic               pc_misalign
);

  logic [1:0]         state;
  logic [31:0]        redirect_pc;
  logic [INSTR_W-1:0] hold_buf;
  logic               drop;
  logic               npc_odd;

  logic               id_load;
  logic               id_bubble;
  logic [INSTR_W-1:0] id_load_instr;

  assign npc_odd = |npc[1:0];

  // Gated by rst so an in-flight request is abandoned the instant reset hits.
  assign imem_req  = !rst && (state != S_HOLD);
  assign imem_addr = IF_PC;

  always_comb begin
    id_load       = 1'b0;
    id_bubble     = 1'b0;
    id_load_instr = imem_rdata;
    case (state)
      S_REQ: begin
        if (!flush) begin
          if (imem_ack) id_load   = !stall && !drop;
          else          id_bubble = !stall;
        end
      end
      S_HOLD: begin
        if (!flush && !stall) begin
          id_load       = 1'b1;
          id_load_instr = hold_buf;
        end
      end
      default: ;
    endcase
  end

  // A flush with no ack in S_REQ must let the old request finish first,
  // so the target is parked in redirect_pc and the late data is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_REQ;
      IF_PC       <= RESET_PC;
      redirect_pc <= RESET_PC;
      hold_buf    <= NOP_INSTR;
      drop        <= 1'b0;
      pc_misalign <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (flush) begin
            pc_misalign <= pc_misalign | npc_odd;
            if (imem_ack) begin
              IF_PC <= align_pc(npc);
              drop  <= 1'b0;
            end else begin
              redirect_pc <= align_pc(npc);
              drop        <= 1'b1;
              state       <= S_DRAIN;
            end
          end else if (imem_ack) begin
            if (stall) begin
              hold_buf <= imem_rdata;
              state    <= S_HOLD;
            end else if (!drop) begin
              IF_PC       <= align_pc(npc);
              pc_misalign <= pc_misalign | npc_odd;
            end
          end
        end
        S_HOLD: begin
          if (flush || !stall) begin
            IF_PC       <= align_pc(npc);
            pc_misalign <= pc_misalign | npc_odd;
            drop        <= 1'b0;
            state       <= S_REQ;
          end
        end
        S_DRAIN: begin
          if (flush) begin
            pc_misalign <= pc_misalign | npc_odd;
            if (imem_ack) begin
              IF_PC <= align_pc(npc);
              drop  <= 1'b0;
              state <= S_REQ;
            end else begin
              redirect_pc <= align_pc(npc);
            end
          end else if (imem_ack) begin
            IF_PC <= redirect_pc;
            drop  <= 1'b0;
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .load      (id_load),
    .bubble    (id_bubble),
    .load_pc   (IF_PC),
    .load_instr(id_load_instr),
    .id_pc     (ID_PC),
    .id_instr  (ID_instr),
    .id_valid  (ID_valid)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit: a transaction-level model of the
// fetch front end plus a variable-latency memory responder.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] npc = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_ack = 1'b0;
  logic [31:0] IF_PC;
  logic [31:0] ID_PC;
  logic [31:0] ID_instr;
  logic        ID_valid;
  logic        pc_misalign;

  int checks = 0;
  int failures = 0;

  // Model: the fetch address, a fetched word waiting for decode (if any),
  // and a redirect target waiting for the killed fetch to complete (if any).
  logic [31:0] m_if_pc, m_id_pc, m_id_instr, m_held_word, m_redirect_tgt;
  bit          m_id_valid, m_mis, m_has_held, m_has_redirect;

  // Memory responder state
  bit mem_busy;
  int mem_cnt;

  // Phase knobs
  int min_lat, max_lat, stall_pct, flush_pct, mis_pct, rst_pct;

  if_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .npc        (npc),
    .stall      (stall),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .IF_PC      (IF_PC),
    .ID_PC      (ID_PC),
    .ID_instr   (ID_instr),
    .ID_valid   (ID_valid),
    .pc_misalign(pc_misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0000_3008) return 32'h8C01_0004;
    return {addr[15:0], ~addr[15:0]};
  endfunction

  function automatic logic [31:0] take_npc(input logic [31:0] n);
    if (n[1:0] != 2'b00) m_mis = 1'b1;
    return {n[31:2], 2'b00};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_if_pc        = RESET_PC;
    m_id_pc        = '0;
    m_id_instr     = NOP_INSTR;
    m_id_valid     = 1'b0;
    m_mis          = 1'b0;
    m_has_held     = 1'b0;
    m_has_redirect = 1'b0;
    m_held_word    = '0;
    m_redirect_tgt = '0;
    mem_busy       = 1'b0;
    mem_cnt        = 0;
  endtask

  task automatic checkReset();
    checkOutput("rst_imem_req", {31'b0, imem_req}, 32'd0);
    checkOutput("rst_IF_PC", IF_PC, RESET_PC);
    checkOutput("rst_pc_misalign", {31'b0, pc_misalign}, 32'd0);
    checkOutput("rst_ID_valid", {31'b0, ID_valid}, 32'd0);
    checkOutput("rst_ID_PC", ID_PC, 32'd0);
    checkOutput("rst_ID_instr", ID_instr, NOP_INSTR);
  endtask

  task automatic checkAll();
    checkOutput("IF_PC", IF_PC, m_if_pc);
    checkOutput("imem_addr", imem_addr, m_if_pc);
    checkOutput("imem_req", {31'b0, imem_req}, {31'b0, !m_has_held});
    checkOutput("ID_valid", {31'b0, ID_valid}, {31'b0, m_id_valid});
    checkOutput("ID_PC", ID_PC, m_id_pc);
    checkOutput("ID_instr", ID_instr, m_id_instr);
    checkOutput("pc_misalign", {31'b0, pc_misalign}, {31'b0, m_mis});
  endtask

  // Drives one cycle of inputs at the falling edge, then advances the model.
  task automatic applyStimulus();
    int r;
    if (int'($urandom_range(99)) < rst_pct) begin
      rst = 1'b1;
      imem_ack = 1'b0;
      stall = 1'b0;
      flush = 1'b0;
      #1;
      checkReset();
      modelReset();
      @(negedge clk);
      rst = 1'b0;
    end

    stall = int'($urandom_range(99)) < stall_pct;
    flush = int'($urandom_range(99)) < flush_pct;

    imem_ack = 1'b0;
    if (!m_has_held) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_cnt  = int'($urandom_range(max_lat, min_lat));
      end
      if (mem_cnt == 0) begin
        imem_ack = 1'b1;
        mem_busy = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
    imem_rdata = imem_ack ? mem_word(m_if_pc) : $urandom;

    r = int'($urandom_range(99));
    if (r < mis_pct)      npc = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(3, 1));
    else if (r < 15)      npc = $urandom & 32'h0000_FFFC;
    else                  npc = m_if_pc + 32'd4;

    if (flush) begin
      m_id_valid = 1'b0;
      m_id_instr = NOP_INSTR;
      if (m_has_held || imem_ack) begin
        m_if_pc        = take_npc(npc);
        m_has_held     = 1'b0;
        m_has_redirect = 1'b0;
      end else begin
        m_redirect_tgt = take_npc(npc);
        m_has_redirect = 1'b1;
      end
    end else if (m_has_held) begin
      if (!stall) begin
        m_id_pc    = m_if_pc;
        m_id_instr = m_held_word;
        m_id_valid = 1'b1;
        m_if_pc    = take_npc(npc);
        m_has_held = 1'b0;
      end
    end else if (imem_ack) begin
      if (m_has_redirect) begin
        m_if_pc        = m_redirect_tgt;
        m_has_redirect = 1'b0;
      end else if (!stall) begin
        m_id_pc    = m_if_pc;
        m_id_instr = imem_rdata;
        m_id_valid = 1'b1;
        m_if_pc    = take_npc(npc);
      end else begin
        m_held_word = imem_rdata;
        m_has_held  = 1'b1;
      end
    end else if (!stall) begin
      m_id_valid = 1'b0;
    end
  endtask

  int ph_cycles[5] = '{6, 12, 40, 60, 500};
  int ph_minlat[5] = '{0, 2, 0, 0, 0};
  int ph_maxlat[5] = '{0, 2, 2, 2, 3};
  int ph_stall[5]  = '{0, 0, 50, 20, 25};
  int ph_flush[5]  = '{0, 0, 0, 20, 12};
  int ph_mis[5]    = '{0, 0, 0, 0, 3};
  int ph_rst[5]    = '{0, 0, 0, 0, 2};

  initial begin
    modelReset();
    repeat (2) @(negedge clk);
    checkReset();
    rst = 1'b0;
    for (int p = 0; p < 5; p++) begin
      min_lat   = ph_minlat[p];
      max_lat   = ph_maxlat[p];
      stall_pct = ph_stall[p];
      flush_pct = ph_flush[p];
      mis_pct   = ph_mis[p];
      rst_pct   = ph_rst[p];
      for (int c = 0; c < ph_cycles[p]; c++) begin
        applyStimulus();
        @(negedge clk);
        checkAll();
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
